// File: rtl/btn_pulse_gen_pkg.sv
// btn_pulse_gen_pkg: debounce FSM state encodings and counter-width helper.
package btn_pulse_gen_pkg;
  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CNT   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CNT = 2'd3;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: 2-flop sync, debounce FSM and press pulse for one button.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_debounce_ch
  import btn_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_CYC   = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse,
  output logic level
);
  localparam int CW = cnt_w(DEBOUNCE_CYC);
  logic          s1, s2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          done, rep_hit;
  assign done = cnt == CW'(DEBOUNCE_CYC - 1);
`ifdef BTN_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_CYC);
  logic [RW-1:0] rcnt;
  assign rep_hit = state == ST_HELD && s2 && rcnt == RW'(REPEAT_CYC - 1);
  // Interval counter is zero outside HELD, so entry and re-entry restart it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rcnt <= '0;
    else      rcnt <= (state == ST_HELD && s2 && !rep_hit) ? rcnt + 1'b1 : '0;
`else
  assign rep_hit = 1'b0 && REPEAT_CYC != 0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      pulse <= 1'b0;
      case (state)
        ST_IDLE:
          if (s2) begin
            state <= ST_PRESS_CNT;
            cnt   <= CW'(1);
          end
        ST_PRESS_CNT:
          if (!s2) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (done) begin
            state <= ST_HELD;
            cnt   <= '0;
            pulse <= 1'b1;
            level <= 1'b1;
          end else cnt <= cnt + 1'b1;
        ST_HELD:
          if (!s2) begin
            state <= ST_RELEASE_CNT;
            cnt   <= CW'(1);
          end else pulse <= rep_hit;
        ST_RELEASE_CNT:
          if (s2) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (done) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else cnt <= cnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: NUM_BTN independent debounced buttons, one pulse per clean press.
// Define BTN_REPEAT_EN to add repeat pulses every REPEAT_CYC cycles while held.
module btn_pulse_gen #(
  parameter int NUM_BTN      = 3,
  parameter int DEBOUNCE_CYC = 20,
  parameter int REPEAT_CYC   = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] pulse_out,
  output logic [NUM_BTN-1:0] level_out
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_in[i]),
      .pulse(pulse_out[i]),
      .level(level_out[i])
    );
  end
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed stimulus with a pulse scoreboard (expected cycle, pulse and level).
module tb_btn_pulse_gen;
  localparam int D = 4;
  typedef struct {
    int         cyc;
    logic [2:0] p;
    logic [2:0] l;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn_in = 3'b111;
  logic [2:0] pulse_out, level_out;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];

  btn_pulse_gen #(.NUM_BTN(3), .DEBOUNCE_CYC(D), .REPEAT_CYC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .pulse_out(pulse_out),
    .level_out(level_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [2:0] p, input logic [2:0] l);
    exp_t e;
    e.cyc = cyc + D + 2;
    e.p   = p;
    e.l   = l;
    q.push_back(e);
  endtask

  // Monitor: every nonzero pulse_out must match the head of the scoreboard.
  always @(negedge clk)
    if (pulse_out != 3'b000) begin
      if (q.size() == 0) chk("unexpected_pulse", int'(pulse_out), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_vec", int'(pulse_out), int'(e.p));
        chk("pulse_level", int'(level_out), int'(e.l));
      end
    end

  initial begin
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("reset_pulse", int'(pulse_out), 0);
      chk("reset_level", int'(level_out), 0);
    end
    btn_in = 3'b000;
    tick(1);
    rst = 1'b1;
    tick(3);
    // single press, held 20 cycles
    btn_in[0] = 1'b1;
    expect_pulse(3'b001, 3'b001);
    tick(5);
    chk("level_before_accept", int'(level_out), 0);
    tick(1);
    chk("level_on_accept", int'(level_out), 1);
    tick(14);
    // glitching channel 1
    for (int i = 0; i < 10; i++) begin
      btn_in[1] = (i % 2 == 0);
      tick(1);
    end
    btn_in[1] = 1'b0;
    tick(6);
    chk("glitch_level", int'(level_out), 1);
    // release with bounce on channel 0
    btn_in[0] = 1'b0;
    tick(1);
    btn_in[0] = 1'b1;
    tick(2);
    btn_in[0] = 1'b0;
    tick(5);
    chk("release_level_held", int'(level_out), 1);
    tick(1);
    chk("release_level_fall", int'(level_out), 0);
    tick(4);
    // simultaneous presses
    btn_in = 3'b101;
    expect_pulse(3'b101, 3'b101);
    tick(10);
    chk("simul_level", int'(level_out), 5);
    btn_in = 3'b000;
    tick(10);
    chk("simul_release", int'(level_out), 0);
    // reset mid-press
    btn_in[0] = 1'b1;
    expect_pulse(3'b001, 3'b001);
    tick(8);
    chk("pre_reset_level", int'(level_out), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_level", int'(level_out), 0);
    chk("async_reset_pulse", int'(pulse_out), 0);
    tick(2);
    rst = 1'b1;
    expect_pulse(3'b001, 3'b001);
    tick(12);
    chk("post_reset_level", int'(level_out), 1);
    tick(20);
    btn_in = 3'b000;
    tick(10);
    chk("final_level", int'(level_out), 0);
    chk("pending_pulses", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
